// File: rtl/rx_packet_arbiter_pkg.sv
// Shared definitions for the FX2 packet controllers: state encoding and default packet size.
package rx_packet_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } rx_state_t;

  localparam int unsigned PKT_WORDS_DEFAULT = 256;

  // States in which FX2 strobes are allowed to pop the granted FIFO.
  function automatic logic is_active(input rx_state_t s);
    return (s == GRANT) || (s == XFER);
  endfunction

endpackage

// File: rtl/rx_packet_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the side not served last.
module rr_arbiter2 (
  input  logic req_a,
  input  logic req_b,
  input  logic last_b,
  output logic gnt_a,
  output logic gnt_b
);

  // One-hot grant; on a tie, last_b = 1 hands the grant to A.
  always_comb begin
    gnt_a = req_a & (~req_b | last_b);
    gnt_b = req_b & (~req_a | ~last_b);
  end

endmodule

// File: rtl/rx_packet_arbiter.sv
// Shares the FX2 read port between rx FIFOs A and B, one full packet per grant.
module rx_packet_arbiter
  import rx_packet_arbiter_pkg::*;
#(
  parameter int unsigned PKT_WORDS = PKT_WORDS_DEFAULT,
  parameter int unsigned LEVEL_W   = 12,
  parameter int unsigned CNT_W     = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bus_reset,
  input  logic               clear_status,
  input  logic               en_a,
  input  logic               en_b,
  input  logic [LEVEL_W-1:0] level_a,
  input  logic [LEVEL_W-1:0] level_b,
  input  logic [15:0]        d_a,
  input  logic [15:0]        d_b,
  input  logic               rd_req,
  output logic               rdreq_a,
  output logic               rdreq_b,
  output logic [15:0]        d_out,
  output logic               packet_rdy,
  output logic               grant_b,
  output logic               req_overrun,
  output logic               aborted
);

  rx_state_t        state, state_n;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic             last_word;
  logic             last_b;
  logic             elig_a, elig_b;
  logic             pick_a, pick_b;
  logic             active;
  logic             step;

  assign elig_a    = en_a & (level_a >= LEVEL_W'(PKT_WORDS));
  assign elig_b    = en_b & (level_b >= LEVEL_W'(PKT_WORDS));
  assign count_inc = count + 1'b1;
  assign last_word = (count_inc == CNT_W'(PKT_WORDS));
  assign active    = is_active(state);
  assign step      = active & rd_req & ~bus_reset;

  rr_arbiter2 u_rr (
    .req_a  (elig_a),
    .req_b  (elig_b),
    .last_b (last_b),
    .gnt_a  (pick_a),
    .gnt_b  (pick_b)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic; GRANT and XFER share the word-count exit so one-word packets work too.
  always_comb begin
    state_n = state;
    if (bus_reset) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE:        if (pick_a | pick_b) state_n = GRANT;
        GRANT, XFER: if (rd_req)          state_n = last_word ? DONE : XFER;
        DONE:        if (!rd_req)         state_n = IDLE;
        default:     state_n = IDLE;
      endcase
    end
  end

  // Pop requests and data mux; strobes outside GRANT/XFER or during bus_reset never pop.
  always_comb begin
    rdreq_a = step & ~grant_b;
    rdreq_b = step &  grant_b;
    d_out   = grant_b ? d_b : d_a;
  end

  // Word counter, grant bookkeeping and packet_rdy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      packet_rdy <= 1'b0;
      grant_b    <= 1'b0;
      last_b     <= 1'b1;
    end else begin
      packet_rdy <= (state_n == GRANT);
      if (bus_reset) begin
        count <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (pick_a | pick_b) begin
              grant_b <= pick_b;
              count   <= '0;
            end
          end
          GRANT, XFER: begin
            if (rd_req) begin
              count <= count_inc;
              if (last_word) last_b <= grant_b;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Sticky status flags; a set event in the same cycle overrides clear_status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_overrun <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      req_overrun <= (rd_req & ((state == IDLE) | (state == DONE)))
                   | (req_overrun & ~clear_status);
      aborted     <= (bus_reset & active) | (aborted & ~clear_status);
    end
  end

endmodule

// File: doc/rx_packet_arbiter.md
Name: rx_packet_arbiter

Overview:
Read-side controller that shares the single FX2 read port between two rx_buffer FIFOs (A, B). Watches each FIFO's read level and grants one FIFO at a time for exactly one 256-word packet. Drives the per-FIFO read requests, the data-output mux select and packet_rdy toward the FX2 interface. Enforces the exact packet word count, so excess FX2 strobes never pop a FIFO.

Parameters:
PKT_WORDS, 256, words per packet; must be less than 2^CNT_W.
LEVEL_W, 12, width of FIFO rdusedw inputs.
CNT_W, 9, word-counter width.

Ports:
clk  in  1  FX2 read-side clock; all logic on posedge.
reset  in  1  asynchronous, active-low; clears all state.
bus_reset  in  1  synchronous abort from the USB side.
clear_status  in  1  synchronous clear of the sticky flags.
en_a  in  1  source A enable.
en_b  in  1  source B enable.
level_a  in  LEVEL_W  FIFO A rdusedw.
level_b  in  LEVEL_W  FIFO B rdusedw.
d_a  in  16  FIFO A q.
d_b  in  16  FIFO B q.
rd_req  in  1  FX2 read strobe, one word per cycle high.
rdreq_a  out  1  pop request to FIFO A.
rdreq_b  out  1  pop request to FIFO B.
d_out  out  16  muxed packet data.
packet_rdy  out  1  granted packet available to FX2.
grant_b  out  1  current or last grant (0 = A, 1 = B).
req_overrun  out  1  sticky: rd_req arrived with no word available to supply.
aborted  out  1  sticky: bus_reset cut a transfer short.

Behaviour:
- Reset (reset = 0) values: state IDLE, count 0, packet_rdy 0, grant_b 0, last_b 1 (so A wins the first tie), req_overrun 0, aborted 0.
- States: IDLE, GRANT, XFER, DONE; all registered.
- Eligibility: elig_x = en_x & (level_x >= PKT_WORDS).
- IDLE:
  - Only one source eligible: grant it.
  - Both eligible: grant the source not equal to last_b (round-robin).
  - On a grant: load grant_b, clear count, go to GRANT; packet_rdy = 1 from the next cycle.
  - Neither eligible: stay in IDLE.
- GRANT:
  - packet_rdy = 1.
  - rd_req high: go to XFER, count = 1; packet_rdy drops the following cycle.
- XFER:
  - Each rd_req cycle increments count.
  - rd_req low: pause and hold count; no timeout.
  - The cycle in which count goes PKT_WORDS-1 -> PKT_WORDS: go to DONE, last_b = grant_b.
- DONE:
  - Stays while rd_req = 1; otherwise returns to IDLE.
  - Re-arbitration can happen no earlier than one cycle after leaving DONE.
- Pop request: rdreq_x = rd_req & (state is GRANT or XFER) & (grant selects x). Combinational, same cycle as rd_req. Exactly PKT_WORDS pops per grant.
- Data path: d_out = grant_b ? d_b : d_a. grant_b holds after DONE, so the trailing FIFO word stays selected.
- req_overrun: set when rd_req = 1 in IDLE or DONE. Such strobes never pop a FIFO.
- bus_reset:
  - From any state: go to IDLE next cycle, count 0, packet_rdy 0.
  - Suppresses rdreq_a and rdreq_b in the same cycle.
  - last_b is left unchanged.
  - If the state was GRANT or XFER, set aborted.
- clear_status: clears req_overrun and aborted. A set event in the same cycle wins.
- Level changes while granted: no effect; a grant is committed until DONE or bus_reset.
- en_x deasserted while granted: the transfer completes; the source is not re-granted afterwards.
- Widths:
  - Level comparison is unsigned, zero-extended to LEVEL_W.
  - count never exceeds PKT_WORDS, so no wrap-around.

Decomposition:
- Shared package: state encoding (IDLE = 0, GRANT = 1, XFER = 2, DONE = 3) and the PKT_WORDS default, so tx/rx controllers agree.
- Sub-module rr_arbiter2: two requests, last_b in, one-hot grant out; purely combinational pick used in IDLE.
- Top-level: FSM, counter, sticky flags, mux.

Test Plan:
- level_a = 300, level_b = 0, en = 11; 256 continuous rd_req -> rdreq_a pulses exactly 256 times, rdreq_b never asserts, packet_rdy high from 1 cycle after grant until 1 cycle after the first rd_req, then DONE -> IDLE.
- level_a = level_b = 512, both enabled; three back-to-back packets -> grant order A, B, A; grant_b = 0, 1, 0.
- Packet in progress; drive 260 rd_req cycles -> exactly 256 pops, req_overrun = 1 from the cycle after the 257th strobe; clear_status -> req_overrun = 0.
- rd_req with gaps (pattern 3 on, 2 off) -> 256 pops total, count holds during gaps, d_out always follows d_a.
- bus_reset after 100 words -> state IDLE next cycle, aborted = 1, no pop in the bus_reset cycle; next grant re-arbitrates from the last completed winner.
- Assert reset (0) mid-XFER asynchronously -> all outputs at reset values immediately; level_b = 256 only after release -> B granted.
